uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Transmit scheduler for the simple UART's TX side. Shares one UART transmitter among `N` byte requesters with round-robin arbitration. Sequences the load/enable handshake for each frame, detects loads the UART fails to accept, and enforces a programmable inter-frame idle gap. It sits between on-chip byte sources and the UART TX port, in the `txclk` domain.

## Interface
Parameters:
- `N`, 4: number of requesters; legal range 2..16.
- `GAP_CYC`, 2: idle `txclk` cycles inserted after each frame; 0 means no gap.
- `LOAD_TO`, 8: cycles allowed for `uart_empty` to fall after a load; range 1..255.

Ports:
- `txclk`  in  1  TX bit clock; single clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  global transmit enable.
- `req`  in  N  per-requester "byte pending"; held until `ack`.
- `data`  in  8*N  requester i byte at `data[8i+7:8i]`; stable while `req[i]`.
- `ack`  out  N  one-cycle pulse: byte of requester i consumed.
- `uart_ld`  out  1  one-cycle load strobe to UART.
- `uart_data`  out  8  byte presented to UART; registered.
- `uart_en`  out  1  UART transmit enable; registered copy of `en`.
- `uart_empty`  in  1  UART holding register empty / frame finished.
- `busy`  out  1  high in any state except IDLE.
- `gnt_id`  out  clog2(N)  index of last granted requester.
- `err`  out  1  sticky load-timeout flag.
- `err_clr`  in  1  clears `err`.
- `frame_cnt`  out  16  completed frames; wraps modulo 2^16.

## Operation
- Reset values: `ack`=0, `uart_ld`=0, `uart_data`=0, `uart_en`=0, `busy`=0, `gnt_id`=0, `err`=0, `frame_cnt`=0. The round-robin pointer resets so requester 0 has top priority. FSM resets to IDLE.
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - Grant condition: `en` && `uart_empty` && any `req`.
  - On grant, pick the first set `req` at or after the pointer, wrapping modulo N.
  - Latch that requester's byte into `uart_data` and its index into `gnt_id`. Set pointer = `gnt_id`+1 mod N. Go to LOAD.
- LOAD (one cycle): `uart_ld`=1 and `ack[gnt_id]`=1. Go to WAIT_BUSY with the timeout counter cleared.
- WAIT_BUSY:
  - `uart_empty`=0: go to WAIT_DONE.
  - Counter reaches `LOAD_TO` first: set `err`, go to IDLE. The byte is dropped, with no retry and no re-ack.
- WAIT_DONE: on `uart_empty`=1, increment `frame_cnt`, then go to GAP if `GAP_CYC`>0, else to IDLE.
- GAP: count `GAP_CYC` cycles, then go to IDLE. `req` is ignored.
- `en` deasserted in WAIT_BUSY, WAIT_DONE or GAP: `uart_en` drops next cycle and the FSM goes to IDLE. An aborted frame is not counted. In LOAD the state completes normally, so `ack` is still issued.
- `err_clr` and a timeout in the same cycle: set wins.
- A requester dropping `req` before `ack` is legal. Arbitration uses only the `req` value in the IDLE decision cycle.

## Timing
- Request to load: `req` sampled high in IDLE at cycle t gives `uart_ld`/`ack` at t+1. `uart_data` is valid from t+1 and holds until the next grant.
- `uart_ld` and `ack` are exactly one cycle wide, at most one `ack` bit per cycle.
- `uart_en` lags `en` by one cycle.
- Frame-to-frame minimum spacing is LOAD + 1 WAIT_BUSY + WAIT_DONE length + `GAP_CYC` + 1 IDLE cycle.
- `frame_cnt` updates on the cycle after `uart_empty` rises in WAIT_DONE.
- `reset` mid-frame: all outputs return to reset values immediately, asynchronously. The UART is resynchronised by its own reset.

## Structure
- Shared package `uart_pkg`: FSM state encoding (IDLE=0, LOAD=1, WAIT_BUSY=2, WAIT_DONE=3, GAP=4, 3-bit) and the `frame_cnt` width constant (16).
- One sub-module: `rr_arbiter`. It is combinational: N-bit `req` plus pointer in, one-hot grant and index out. It is reusable for the RX-side distributor.
- Top level holds the FSM, gap/timeout counters, data mux and status registers.

## Test plan
- Single request: `req[2]`=1 with `data`=0xA5; UART model drops `uart_empty` 1 cycle after load and raises it 10 cycles later. Required: `uart_ld`/`ack[2]` one cycle after `req`, `uart_data`=0xA5, `frame_cnt`=1, `gnt_id`=2.
- Fairness: all four `req` held high for 8 frames. Required: grant order 0,1,2,3,0,1,2,3 with correct per-requester bytes.
- Timeout: UART model never drops `uart_empty`. Required: `err`=1 exactly `LOAD_TO` cycles after WAIT_BUSY entry, FSM back in IDLE, `frame_cnt` unchanged. Then `err_clr` gives `err`=0.
- Gap: `GAP_CYC`=5 with back-to-back requests. Required: at least 5 idle cycles between `uart_empty` rising and the next `uart_ld`. Repeat with `GAP_CYC`=0.
- Enable abort: drop `en` in WAIT_DONE. Required: `uart_en`=0 next cycle, FSM in IDLE, no `frame_cnt` increment; no new grant until `en`=1.
- Reset mid-frame: assert `reset` during WAIT_DONE. Required: all outputs at reset values in the same cycle; the next grant goes to requester 0 when all request.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared types and constants for the UART TX scheduler family.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } tx_state_t;

    localparam int FRAME_CNT_W = 16;

    // Increment an index with wrap-around at n.
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational round-robin pick: first set request at/after ptr.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    int w_j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        w_j   = 0;
        for (int i = 0; i < N; i++) begin
            w_j = (int'(ptr) + i) % N;
            if (!valid && req[w_j]) begin
                valid    = 1'b1;
                gnt[w_j] = 1'b1;
                idx      = IW'(w_j);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_sched                                                        |
// | Round-robin scheduler sharing one UART transmitter among N sources.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N       = 4,
    parameter int GAP_CYC = 2,
    parameter int LOAD_TO = 8
) (
    input  logic                   txclk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [N-1:0]           req,
    input  logic [8*N-1:0]         data,
    output logic [N-1:0]           ack,
    output logic                   uart_ld,
    output logic [7:0]             uart_data,
    output logic                   uart_en,
    input  logic                   uart_empty,
    output logic                   busy,
    output logic [$clog2(N)-1:0]   gnt_id,
    output logic                   err,
    input  logic                   err_clr,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int IW = $clog2(N);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] c_gap_last = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [7:0]    c_to_last  = 8'(LOAD_TO - 1);

    tx_state_t      r_state;
    logic [IW-1:0]  r_ptr;
    logic [7:0]     r_to_cnt;
    logic [GW-1:0]  r_gap_cnt;

    logic [N-1:0]   w_gnt;
    logic [IW-1:0]  w_idx;
    logic           w_valid;
    logic [7:0]     w_byte;
    logic [IW-1:0]  w_next_ptr;

    rr_arbiter #(.N(N)) u_arb (
        .req   (req),
        .ptr   (r_ptr),
        .gnt   (w_gnt),
        .idx   (w_idx),
        .valid (w_valid)
    );

    assign w_byte     = data[8*int'(w_idx) +: 8];
    assign w_next_ptr = IW'(wrap_inc(int'(w_idx), N));

    // Strobes are asserted on entry to LOAD so they are registered and
    // exactly one cycle wide; the default below clears them again.
    always_ff @(posedge txclk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_to_cnt  <= '0;
            r_gap_cnt <= '0;
            ack       <= '0;
            uart_ld   <= 1'b0;
            uart_data <= '0;
            uart_en   <= 1'b0;
            busy      <= 1'b0;
            gnt_id    <= '0;
            err       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            uart_en <= en;
            uart_ld <= 1'b0;
            ack     <= '0;
            if (err_clr) begin
                err <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (en && uart_empty && w_valid) begin
                        uart_data <= w_byte;
                        gnt_id    <= w_idx;
                        r_ptr     <= w_next_ptr;
                        uart_ld   <= 1'b1;
                        ack       <= w_gnt;
                        busy      <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    r_to_cnt <= '0;
                    r_state  <= ST_WAIT_BUSY;
                end

                ST_WAIT_BUSY: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (!uart_empty) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_to_cnt == c_to_last) begin
                        // Byte is dropped; the requester was already acked.
                        err     <= 1'b1;
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end

                ST_WAIT_DONE: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (uart_empty) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        r_gap_cnt <= '0;
                        if (GAP_CYC > 0) begin
                            r_state <= ST_GAP;
                        end else begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end

                ST_GAP: begin
                    if (!en || r_gap_cnt == c_gap_last) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : uart_tx_sched
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_sched                                                     |
// | Directed scoreboard bench: one DUT with GAP_CYC=5, one with 0.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_tx_sched;

    localparam int N       = 4;
    localparam int LOAD_TO = 8;

    logic           txclk = 1'b0;
    logic           reset;
    logic           en;
    logic           err_clr;
    logic           stall;
    logic [8*N-1:0] data;

    logic [N-1:0]   req_a    [2];
    logic [N-1:0]   ack_a    [2];
    logic           ld_a     [2];
    logic [7:0]     udata_a  [2];
    logic           uen_a    [2];
    logic           uempty   [2];
    logic           busy_a   [2];
    logic [1:0]     gnt_a    [2];
    logic           err_a    [2];
    logic [15:0]    fc_a     [2];
    int             ucnt     [2];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         idx;
        logic [7:0] b;
    } exp_t;
    exp_t exp_q[$];

    always #5 txclk = ~txclk;

    uart_tx_sched #(.N(N), .GAP_CYC(5), .LOAD_TO(LOAD_TO)) dut (
        .txclk(txclk), .reset(reset), .en(en), .req(req_a[0]), .data(data),
        .ack(ack_a[0]), .uart_ld(ld_a[0]), .uart_data(udata_a[0]),
        .uart_en(uen_a[0]), .uart_empty(uempty[0]), .busy(busy_a[0]),
        .gnt_id(gnt_a[0]), .err(err_a[0]), .err_clr(err_clr),
        .frame_cnt(fc_a[0])
    );

    uart_tx_sched #(.N(N), .GAP_CYC(0), .LOAD_TO(LOAD_TO)) dut_nogap (
        .txclk(txclk), .reset(reset), .en(en), .req(req_a[1]), .data(data),
        .ack(ack_a[1]), .uart_ld(ld_a[1]), .uart_data(udata_a[1]),
        .uart_en(uen_a[1]), .uart_empty(uempty[1]), .busy(busy_a[1]),
        .gnt_id(gnt_a[1]), .err(err_a[1]), .err_clr(err_clr),
        .frame_cnt(fc_a[1])
    );

    // UART model: empty falls the cycle after a load, rises 10 cycles later.
    always @(posedge txclk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                uempty[k] <= 1'b1;
                ucnt[k]   <= 0;
            end else if (ld_a[k] && !stall) begin
                uempty[k] <= 1'b0;
                ucnt[k]   <= 10;
            end else if (ucnt[k] != 0) begin
                ucnt[k] <= ucnt[k] - 1;
                if (ucnt[k] == 1) uempty[k] <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        exp_t e;
        e.idx = i;
        e.b   = b;
        exp_q.push_back(e);
    endtask

    // Compare the load in the current cycle against the scoreboard head.
    task automatic check_ld(input int k);
        exp_t e;
        check("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("uart_ld", ld_a[k], 1);
            check("gnt_id", gnt_a[k], e.idx);
            check("uart_data", udata_a[k], e.b);
            check("ack", ack_a[k], 32'(1) << e.idx);
        end
        tick();
        check("ld_width", ld_a[k], 0);
        check("ack_width", ack_a[k], 0);
    endtask

    task automatic wait_ld(input int k);
        int n = 0;
        while (!ld_a[k] && n < 200) begin
            tick();
            n++;
        end
        check("ld_seen", ld_a[k], 1);
        check_ld(k);
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy_a[k] && n < 200) begin
            tick();
            n++;
        end
        check("idle_reached", busy_a[k], 0);
    endtask

    // Cycles strictly between uart_empty rising and the next uart_ld.
    task automatic measure_gap(input int k, output int gap);
        int   t      = 0;
        int   t_rise = -1000;
        logic prev   = uempty[k];
        while (!ld_a[k] && t < 300) begin
            tick();
            t++;
            if (!prev && uempty[k]) t_rise = t;
            prev = uempty[k];
        end
        gap = t - t_rise - 1;
    endtask

    initial begin
        int rem [N];
        int g;
        int gap;
        int ldc;

        reset    = 1'b1;
        en       = 1'b0;
        err_clr  = 1'b0;
        stall    = 1'b0;
        data     = '0;
        req_a[0] = '0;
        req_a[1] = '0;
        tick();
        tick();

        check("rst_ack", ack_a[0], 0);
        check("rst_ld", ld_a[0], 0);
        check("rst_data", udata_a[0], 0);
        check("rst_uen", uen_a[0], 0);
        check("rst_busy", busy_a[0], 0);
        check("rst_gnt", gnt_a[0], 0);
        check("rst_err", err_a[0], 0);
        check("rst_fc", fc_a[0], 0);

        reset = 1'b0;
        en    = 1'b1;
        tick();
        check("uen_follow", uen_a[0], 1);

        // Fairness: all four requesting, two frames each.
        for (int i = 0; i < N; i++) begin
            data[8*i +: 8] = 8'(8'h10 + i);
            rem[i] = 2;
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 8'(8'h10 + i));
        req_a[0] = 4'hF;
        for (int f = 0; f < 8; f++) begin
            wait_ld(0);
            g = int'(gnt_a[0]);
            rem[g]--;
            if (rem[g] == 0) req_a[0][g] = 1'b0;
        end
        wait_idle(0);
        check("fc_fair", fc_a[0], 8);

        // Single request: load exactly one cycle after req.
        data[23:16] = 8'hA5;
        req_a[0]    = 4'b0100;
        push(2, 8'hA5);
        tick();
        check_ld(0);
        req_a[0] = '0;
        wait_idle(0);
        check("fc_single", fc_a[0], 9);
        check("gnt_single", gnt_a[0], 2);

        // Timeout: UART never accepts.
        stall      = 1'b1;
        data[15:8] = 8'h3C;
        req_a[0]   = 4'b0010;
        push(1, 8'h3C);
        wait_ld(0);
        req_a[0] = '0;
        repeat (LOAD_TO - 1) tick();
        check("err_early", err_a[0], 0);
        check("busy_wait", busy_a[0], 1);
        tick();
        check("err_set", err_a[0], 1);
        check("busy_to", busy_a[0], 0);
        check("fc_to", fc_a[0], 9);
        stall = 1'b0;
        repeat (3) tick();
        check("err_sticky", err_a[0], 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", err_a[0], 0);

        // Gap, GAP_CYC=5: pointer sits at 2, so 3 then 0.
        data[7:0]   = 8'h5A;
        data[31:24] = 8'hC3;
        req_a[0]    = 4'b1001;
        push(3, 8'hC3);
        push(0, 8'h5A);
        wait_ld(0);
        req_a[0][3] = 1'b0;
        measure_gap(0, gap);
        check("gap5", gap, 6);
        check_ld(0);
        req_a[0][0] = 1'b0;
        wait_idle(0);
        check("fc_gap5", fc_a[0], 11);

        // Gap, GAP_CYC=0 on the second instance (pointer at 0).
        req_a[1] = 4'b1001;
        push(0, 8'h5A);
        push(3, 8'hC3);
        wait_ld(1);
        req_a[1][0] = 1'b0;
        measure_gap(1, gap);
        check("gap0", gap, 1);
        check_ld(1);
        req_a[1][3] = 1'b0;
        wait_idle(1);
        check("fc_gap0", fc_a[1], 2);

        // Enable abort during WAIT_DONE.
        req_a[0] = 4'b0100;
        push(2, 8'hA5);
        wait_ld(0);
        req_a[0] = '0;
        tick();
        tick();
        check("busy_pre_abort", busy_a[0], 1);
        en = 1'b0;
        tick();
        check("uen_abort", uen_a[0], 0);
        check("busy_abort", busy_a[0], 0);
        check("fc_abort", fc_a[0], 11);
        req_a[0] = 4'b0001;
        ldc = 0;
        repeat (15) begin
            tick();
            if (ld_a[0]) ldc++;
        end
        check("no_grant_dis", ldc, 0);
        check("fc_dis", fc_a[0], 11);
        en = 1'b1;
        push(0, 8'h5A);
        wait_ld(0);
        req_a[0] = '0;
        wait_idle(0);
        check("fc_resume", fc_a[0], 12);

        // Reset mid-frame; next grant must go to requester 0.
        req_a[0] = 4'hF;
        push(1, 8'h3C);
        wait_ld(0);
        tick();
        reset = 1'b1;
        #1;
        check("mrst_ack", ack_a[0], 0);
        check("mrst_ld", ld_a[0], 0);
        check("mrst_data", udata_a[0], 0);
        check("mrst_uen", uen_a[0], 0);
        check("mrst_busy", busy_a[0], 0);
        check("mrst_gnt", gnt_a[0], 0);
        check("mrst_err", err_a[0], 0);
        check("mrst_fc", fc_a[0], 0);
        tick();
        reset = 1'b0;
        push(0, 8'h5A);
        wait_ld(0);
        req_a[0] = '0;
        wait_idle(0);
        check("fc_post_rst", fc_a[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_tx_sched
`default_nettype wire
